// File: rtl/rj_rx_deser.sv
// rj lane receiver: lane-clock recovery, sync hunt, MSB-first word deserializer.
// Define RJ_RX_PARITY_EN to expect one even-parity bit after every data word.
module rj_rx_deser #(
    parameter int                DATA_W   = 8,
    parameter int                SYNC_W   = 8,
    parameter logic [SYNC_W-1:0] SYNC_PAT = 8'hA5,
    parameter int                TIMEOUT  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        rj_lane,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              rx_lock,
    output logic              rx_overrun,
    output logic              rx_par_err
);

`ifdef RJ_RX_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int FRAME_W = DATA_W + PAR_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam int TO_W    = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 1);
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

    typedef enum logic {
        HUNT,
        DATA
    } state_t;

    state_t              state;
    logic [1:0]          sync1;
    logic [1:0]          sync2;
    logic                clk_q;
    logic                samp;
    logic                bit_in;
    logic [SYNC_W-1:0]   hist;
    logic [SYNC_W-1:0]   hist_nxt;
    logic [FRAME_W-1:0]  shreg;
    logic [CNT_W-1:0]    bit_cnt;
    logic [TO_W-1:0]     to_cnt;
    logic                word_done;
    logic                frame_ok;
    logic [DATA_W-1:0]   word_data;

    assign samp      = sync2[1] & ~clk_q;
    assign bit_in    = sync2[0];
    assign hist_nxt  = {hist[SYNC_W-2:0], bit_in};
    assign word_data = shreg[FRAME_W-1 -: DATA_W];

`ifdef RJ_RX_PARITY_EN
    assign frame_ok = ~^shreg;
`else
    assign frame_ok = 1'b1;
`endif

    // two-flop synchronizer on both lane bits plus lane-clock edge history
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 2'b00;
            sync2 <= 2'b00;
            clk_q <= 1'b0;
        end else begin
            sync1 <= rj_lane;
            sync2 <= sync1;
            clk_q <= sync2[1];
        end
    end

    // hunt/data state machine, bit counting and lane-clock watchdog
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HUNT;
            hist      <= '0;
            shreg     <= '0;
            bit_cnt   <= '0;
            to_cnt    <= '0;
            word_done <= 1'b0;
            rx_lock   <= 1'b0;
        end else begin
            word_done <= 1'b0;
            if (samp) begin
                to_cnt <= '0;
            end else if (to_cnt != TO_MAX) begin
                to_cnt <= to_cnt + 1'b1;
            end
            unique case (state)
                HUNT: begin
                    if (samp) begin
                        hist <= hist_nxt;
                        if (hist_nxt == SYNC_PAT) begin
                            state   <= DATA;
                            rx_lock <= 1'b1;
                            bit_cnt <= '0;
                        end
                    end
                end
                DATA: begin
                    if (samp) begin
                        shreg <= {shreg[FRAME_W-2:0], bit_in};
                        if (bit_cnt == CNT_LAST) begin
                            bit_cnt   <= '0;
                            word_done <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else if (to_cnt == TO_LAST) begin
                        state   <= HUNT;
                        rx_lock <= 1'b0;
                        hist    <= '0;
                        bit_cnt <= '0;
                    end
                end
                default: begin
                    state <= HUNT;
                end
            endcase
        end
    end

    // one-entry output register with overrun detection
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            rx_overrun <= 1'b0;
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            if (word_done && frame_ok) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= word_data;
                    rx_valid <= 1'b1;
                end else begin
                    rx_overrun <= 1'b1;
                end
            end
        end
    end

`ifdef RJ_RX_PARITY_EN
    // flag frames whose even parity fails; such words are dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_par_err <= 1'b0;
        end else begin
            rx_par_err <= word_done & ~frame_ok;
        end
    end
`else
    assign rx_par_err = 1'b0;
`endif

endmodule

// File: tb/tb_rj_rx_deser.sv
// Randomized bench for rj_rx_deser with an in-order delivery model.
// Build with RJ_RX_PARITY_EN defined to exercise the parity path.
module tb_rj_rx_deser;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] rj_lane = 2'b00;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_lock;
    logic       rx_overrun;
    logic       rx_par_err;

    rj_rx_deser dut (
        .clk        (clk),
        .rst        (rst),
        .rj_lane    (rj_lane),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .rx_lock    (rx_lock),
        .rx_overrun (rx_overrun),
        .rx_par_err (rx_par_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int         cmp_cnt = 0;
    int         err_cnt = 0;
    logic [7:0] sentq[$];
    int         credit = 0;
    int         hs_cnt = 0;
    int         ov_cnt = 0;
    int         pe_cnt = 0;
    logic [7:0] last_hs = 8'h00;
    int         rise_cyc = 0;
    logic       rand_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic lane_rise(input logic b, input int lo);
        rj_lane = {1'b0, b};
        wait_cyc(lo);
        rj_lane = {1'b1, b};
        rise_cyc = cyc;
    endtask

    task automatic send_bit(input logic b, input int hi, input int lo);
        lane_rise(b, lo);
        wait_cyc(hi);
    endtask

    task automatic send_bits(input logic [31:0] v, input int n,
                             input int hi, input int lo);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i], hi, lo);
    endtask

    task automatic send_word(input logic [7:0] w, input int hi, input int lo);
        sentq.push_back(w);
        send_bits({24'h0, w}, 8, hi, lo);
`ifdef RJ_RX_PARITY_EN
        send_bit(^w, hi, lo);
`endif
    endtask

    task automatic send_sync(input int hi, input int lo);
        send_bits(32'hA5, 8, hi, lo);
    endtask

    task automatic do_reset();
        rj_lane = 2'b00;
        rst = 1'b1;
        wait_cyc(2);
        rst = 1'b0;
        sentq.delete();
        credit = 0;
        wait_cyc(2);
    endtask

    task automatic end_check(input string name);
        rx_ready = 1'b1;
        wait_cyc(20);
        chk({name, "_leftover"}, sentq.size(), credit);
        sentq.delete();
        credit = 0;
    endtask

    task automatic chk_zero(input string name);
        chk(name, {20'h0, rx_data, rx_valid, rx_lock, rx_overrun, rx_par_err},
            32'h0);
    endtask

    // compare process: every accepted word must be the next sent word,
    // skipping only as many words as overrun pulses have reported
    initial begin
        logic       pv;
        logic       phs;
        logic       prst;
        logic [7:0] pd;
        pv = 1'b0;
        phs = 1'b0;
        prst = 1'b1;
        pd = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst && !prst) begin
                if (pv && !phs) begin
                    chk("hold_valid", {31'h0, rx_valid}, 32'h1);
                    chk("hold_data", {24'h0, rx_data}, {24'h0, pd});
                end
                if (rx_overrun) begin
                    ov_cnt++;
                    credit++;
                    chk("ovr_keeps_valid", {31'h0, rx_valid}, 32'h1);
                end
                if (rx_par_err) pe_cnt++;
                if (rx_valid && rx_ready) begin
                    while (sentq.size() > 0 && sentq[0] != rx_data && credit > 0) begin
                        void'(sentq.pop_front());
                        credit--;
                    end
                    if (sentq.size() == 0) begin
                        cmp_cnt++;
                        err_cnt++;
                        $display("FAIL unexpected_word: got %0h want none", rx_data);
                    end else begin
                        chk("word", {24'h0, rx_data}, {24'h0, sentq[0]});
                        void'(sentq.pop_front());
                    end
                    hs_cnt++;
                    last_hs = rx_data;
                end
            end
            pv = rx_valid;
            phs = rx_valid & rx_ready;
            pd = rx_data;
            prst = rst;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         h0;
        int         o0;
        int         p0;
        int         r;
        logic [8:0] frame;
        int         fn;
        logic [7:0] base;
        logic [7:0] step;

        // reset with the lane toggling
        rst = 1'b1;
        rx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            rj_lane = rj_lane ^ 2'b11;
            chk_zero("reset_outputs");
        end
        rj_lane = 2'b00;
        wait_cyc(1);
        rst = 1'b0;
        wait_cyc(6);
        chk_zero("idle_after_reset");

        // sync then one word, consumer always ready
        send_bits(32'h52, 7, 10, 10);
        lane_rise(1'b1, 10);
        wait_cyc(2);
        chk("lock_before_sync", {31'h0, rx_lock}, 32'h0);
        wait_cyc(2);
        chk("lock_after_sync", {31'h0, rx_lock}, 32'h1);
        wait_cyc(6);
        h0 = hs_cnt;
        send_word(8'h3C, 10, 10);
        wait_cyc(10);
        chk("a_one_word", hs_cnt - h0, 32'd1);
        chk("a_data", {24'h0, last_hs}, 32'h3C);
        chk("a_valid_clear", {31'h0, rx_valid}, 32'h0);
        end_check("a");

        // overrun with consumer stalled
        do_reset();
        rx_ready = 1'b0;
        send_sync(10, 10);
        o0 = ov_cnt;
        send_word(8'h11, 10, 10);
        send_word(8'h22, 10, 10);
        wait_cyc(8);
        chk("b_valid", {31'h0, rx_valid}, 32'h1);
        chk("b_held", {24'h0, rx_data}, 32'h11);
        chk("b_overruns", ov_cnt - o0, 32'd1);
        rx_ready = 1'b1;
        wait_cyc(4);
        chk("b_accepted", {24'h0, last_hs}, 32'h11);
        chk("b_valid_clear", {31'h0, rx_valid}, 32'h0);
        end_check("b");

        // lane clock stops mid-word
        do_reset();
        rx_ready = 1'b1;
        send_sync(10, 10);
        h0 = hs_cnt;
        send_bits(32'h5, 3, 10, 10);
        r = rise_cyc;
        wait_cyc(r + 60 - cyc);
        chk("c_lock_held", {31'h0, rx_lock}, 32'h1);
        wait_cyc(10);
        chk("c_lock_lost", {31'h0, rx_lock}, 32'h0);
        chk("c_no_valid", {31'h0, rx_valid}, 32'h0);
        chk("c_no_word", hs_cnt - h0, 32'd0);
        send_sync(10, 10);
        chk("c_relock", {31'h0, rx_lock}, 32'h1);
        send_word(8'h5A, 10, 10);
        wait_cyc(10);
        chk("c_data", {24'h0, last_hs}, 32'h5A);
        end_check("c");

        // completion in the same cycle as acceptance of the held word
        do_reset();
        rx_ready = 1'b0;
        send_sync(10, 10);
        send_word(8'h5C, 10, 10);
        o0 = ov_cnt;
        sentq.push_back(8'hC3);
`ifdef RJ_RX_PARITY_EN
        frame = {8'hC3, ^8'hC3};
        fn = 9;
`else
        frame = {1'b0, 8'hC3};
        fn = 8;
`endif
        send_bits({23'h0, frame} >> 1, fn - 1, 10, 10);
        lane_rise(frame[0], 10);
        wait_cyc(3);
        rx_ready = 1'b1;
        wait_cyc(1);
        rx_ready = 1'b0;
        chk("d_valid_stays", {31'h0, rx_valid}, 32'h1);
        chk("d_new_data", {24'h0, rx_data}, 32'hC3);
        chk("d_no_overrun", ov_cnt - o0, 32'd0);
        chk("d_old_taken", {24'h0, last_hs}, 32'h5C);
        wait_cyc(6);
        end_check("d");
        chk("d_drained", {24'h0, last_hs}, 32'hC3);

`ifdef RJ_RX_PARITY_EN
        // bad parity drops the word
        do_reset();
        rx_ready = 1'b1;
        send_sync(10, 10);
        p0 = pe_cnt;
        h0 = hs_cnt;
        o0 = ov_cnt;
        send_bits({23'h0, 8'h0F, 1'b1}, 9, 10, 10);
        wait_cyc(8);
        chk("e_par_err", pe_cnt - p0, 32'd1);
        chk("e_no_word", hs_cnt - h0, 32'd0);
        chk("e_no_ovr", ov_cnt - o0, 32'd0);
        send_word(8'h0F, 10, 10);
        wait_cyc(8);
        chk("e_data", {24'h0, last_hs}, 32'h0F);
        end_check("e");
`else
        p0 = pe_cnt;
`endif

        // reset mid-word clears the held word too
        do_reset();
        rx_ready = 1'b0;
        send_sync(10, 10);
        send_word(8'h77, 10, 10);
        send_bits(32'hA, 4, 10, 10);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            rj_lane = rj_lane ^ 2'b10;
            chk_zero("f_reset_outputs");
        end
        sentq.delete();
        credit = 0;
        rj_lane = 2'b00;
        rst = 1'b0;
        wait_cyc(3);
        h0 = hs_cnt;
        rx_ready = 1'b1;
        send_bits(32'h33, 8, 10, 10);
        wait_cyc(10);
        chk("f_no_lock", {31'h0, rx_lock}, 32'h0);
        chk("f_no_word", hs_cnt - h0, 32'd0);
        end_check("f");

        // randomized words, lane timing and consumer backpressure
        do_reset();
        base = 8'($urandom);
        step = 8'($urandom) | 8'h01;
        send_sync($urandom_range(3, 7), $urandom_range(3, 7));
        rand_on = 1'b1;
        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    send_word(base + 8'(i) * step, $urandom_range(3, 7),
                              $urandom_range(3, 7));
                end
                rand_on = 1'b0;
            end
            begin
                while (rand_on) begin
                    @(posedge clk);
                    #1;
                    rx_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        end_check("g");
        chk("g_no_par_err", pe_cnt - p0, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
